// File: rtl/aud_fifo_feeder.sv
// Purpose : CPU-fed sample FIFO that paces pushes into the codec DAC FIFO, with low-water IRQ.
// Latency : readdata 1 cycle after read; first aud_wrreq 1 cycle after IDLE sees en && count>0 && !full_s.
// Backpressure: codec full is synchronised; after every push the sequencer holds off SYNC_STAGES cycles.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   address/write/writedata/read/readdata   Avalon-MM slave (0 DATA, 1 CTRL, 2 STATUS, 3 THRESH)
//   aud_full            codec FIFO full flag (asynchronous to clk)
//   aud_wrreq/aud_data  one-cycle push strobe and sample to the codec FIFO
//   irq                 level interrupt: low-water mark reached or overflow

module aud_fifo_feeder #(
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic              read,
    output logic [31:0]       readdata,
    input  logic              aud_full,
    output logic              aud_wrreq,
    output logic [DATA_W-1:0] aud_data,
    output logic              irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int HCW   = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

    localparam logic [PW-1:0]  PTR_ONE   = 1;
    localparam logic [CW-1:0]  CNT_ONE   = 1;
    localparam logic [CW-1:0]  CNT_FULL  = CW'(DEPTH);
    localparam logic [HCW-1:0] HOLD_ONE  = 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(SYNC_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        HOLD = 2'd2
    } state_t;

    // ---------------- state ----------------
    logic [DATA_W-1:0]      mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   en_q, en_d;
    logic                   irq_en_q, irq_en_d;
    logic [CW-1:0]          thresh_q, thresh_d;
    logic                   ovf_q, ovf_d;
    logic                   udr_q, udr_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [HCW-1:0]         hold_q, hold_d;
    logic [DATA_W-1:0]      last_q, last_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   irq_q, irq_d;

    // ---------------- decode ----------------
    logic wr_data, wr_ctrl, wr_stat, wr_thr, flush;
    logic push_ok, pop, udr_set, full_s;
    logic [DATA_W-1:0] head;
    logic [31:0] status;
    logic unused_wdata;

    assign wr_data = write && (address == 2'd0);
    assign wr_ctrl = write && (address == 2'd1);
    assign wr_stat = write && (address == 2'd2);
    assign wr_thr  = write && (address == 2'd3);
    assign flush   = wr_ctrl && writedata[2];

    // Only some writedata bits matter for a given parameter set.
    assign unused_wdata = ^writedata;

    assign full_s = sync_q[SYNC_STAGES-1];
    assign head   = mem_q[rd_ptr_q];

    // A DATA write into a full FIFO is dropped even if this cycle also pops.
    assign push_ok = wr_data && (count_q != CNT_FULL);

    // ---------------- sequencer FSM ----------------
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        udr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_q && !full_s) begin
                    if (count_q != '0) state_d = PUSH;
                    else               udr_set = 1'b1;
                end
            end
            PUSH: begin
                pop     = 1'b1;
                state_d = HOLD;
                hold_d  = '0;
            end
            HOLD: begin
                // Give a full flag raised by this push time to cross the synchroniser.
                if (hold_q == HOLD_LAST) state_d = IDLE;
                else                     hold_d  = hold_q + HOLD_ONE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            hold_d  = '0;
        end
    end

    // The strobe comes straight from the state flop so reset removes it asynchronously.
    assign aud_wrreq = (state_q == PUSH);
    assign aud_data  = (state_q == PUSH) ? head : last_q;

    // ---------------- datapath / registers ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        udr_d    = udr_q;
        last_d   = last_q;
        rdata_d  = rdata_q;
        status   = '0;

        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            last_d   = head;
        end
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        if (wr_ctrl) begin
            en_d     = writedata[0];
            irq_en_d = writedata[1];
        end
        if (wr_thr) thresh_d = writedata[CW-1:0];

        // Clears apply first so a simultaneous set event is never lost.
        if (wr_stat && writedata[16]) ovf_d = 1'b0;
        if (wr_stat && writedata[17]) udr_d = 1'b0;
        if (wr_data && !push_ok)      ovf_d = 1'b1;
        if (udr_set)                  udr_d = 1'b1;

        status[17]      = udr_q;
        status[16]      = ovf_q;
        status[9]       = (count_q == '0);
        status[8]       = (count_q == CNT_FULL);
        status[CW-1:0]  = count_q;

        if (read) begin
            unique case (address)
                2'd0:    rdata_d = '0;
                2'd1:    rdata_d = {30'd0, irq_en_q, en_q};
                2'd2:    rdata_d = status;
                default: rdata_d = 32'(thresh_q);
            endcase
        end
    end

    // Computed from next-state values so irq tracks register writes without an extra cycle.
    assign irq_d = irq_en_d && en_d && ((count_d <= thresh_d) || ovf_d);

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = aud_full;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= '0;
            ovf_q    <= 1'b0;
            udr_q    <= 1'b0;
            sync_q   <= '0;
            state_q  <= IDLE;
            hold_q   <= '0;
            last_q   <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (push_ok) mem_q[wr_ptr_q] <= writedata[DATA_W-1:0];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            udr_q    <= udr_d;
            sync_q   <= sync_d;
            state_q  <= state_d;
            hold_q   <= hold_d;
            last_q   <= last_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule
